// File: rtl/rsa_pkg.sv
// rsa_pkg
// Shared definitions for the modular exponentiation core and its modular
// multiplier: the controller state encoding, the default operand width and a
// helper that gives the fixed start-to-done latency for a given width.
package rsa_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REDUCE,
        SQR,
        MUL,
        DONE
    } state_t;

    // Cycles from the edge that samples start to the edge where done is high:
    // two control cycles plus 2W+1 products of W+1 cycles each.
    function automatic int lat(input int w);
        return 2 + (2 * w + 1) * (w + 1);
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul
// Interleaved shift-add modular multiplier computing p = a*b mod m.
// One load cycle latches the operands, then WIDTH iteration cycles walk a from
// its MSB down. done is high during the final iteration cycle, and p carries
// the finished product in that same cycle, so the caller captures p on the
// edge that ends the operation.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : load a, b, m and begin (ignored while running)
//   a, b, m  : operands; b must be <= m so each step stays below 3m
//   done     : high in the last iteration cycle
//   p        : product output, valid while done is high
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    // Two guard bits hold 2*acc + b, which can reach 3m-1.
    localparam int IW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh;
    logic [IW-1:0]    b_r;
    logic [IW-1:0]    m_r;
    logic [IW-1:0]    acc2;
    logic [IW-1:0]    dbl;
    logic [IW-1:0]    s1;
    logic [IW-1:0]    s2;
    logic [CW-1:0]    cnt;
    logic             running;
    logic             unused_hi;

    // One iteration step: double, add b when the current a bit is set, then
    // fold back into [0, m) with at most two subtractions.
    always_comb begin
        dbl = {acc2[IW-2:0], 1'b0} + (a_sh[WIDTH-1] ? b_r : '0);
        s1  = (dbl >= m_r) ? dbl - m_r : dbl;
        s2  = (s1 >= m_r) ? s1 - m_r : s1;
    end

    assign p         = s2[WIDTH-1:0];
    assign done      = running && (cnt == CW'(1));
    assign unused_hi = ^{s2[IW-1:WIDTH], acc2[IW-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_r     <= '0;
            m_r     <= '0;
            acc2    <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start && !running) begin
            a_sh    <= a;
            b_r     <= IW'(b);
            m_r     <= IW'(m);
            acc2    <= '0;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            acc2 <= s2;
            a_sh <= a_sh << 1;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
// Constant-time modular exponentiation: result = base^exp mod m, using
// left-to-right square-and-multiply where every exponent bit costs one
// square and one multiply regardless of its value. A single rsa_modmul
// instance is shared by the REDUCE, SQR and MUL steps.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   start                 : begin; sampled only in IDLE
//   base_i, exp_i, mod_i  : operands, latched when start is accepted
//   busy                  : high while an operation is in progress
//   done                  : one-cycle pulse when result/err are valid
//   err                   : modulus was zero; held until the next start
//   result                : final value; held until overwritten
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0] mod_i,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_val;
    logic [BW-1:0]    bit_idx;
    logic             mm_pending;

    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic             mm_done;
    logic [WIDTH-1:0] mm_p;
    logic [WIDTH-1:0] mul_acc;

    rsa_modmul #(
        .WIDTH(WIDTH)
    ) u_modmul (
        .clk  (clk),
        .rst  (rst),
        .start(mm_start),
        .a    (mm_a),
        .b    (mm_b),
        .m    (mod_r),
        .done (mm_done),
        .p    (mm_p)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; each arithmetic state waits for its product.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = (mod_r == '0) ? DONE : REDUCE;
            REDUCE:  if (mm_done) state_next = SQR;
            SQR:     if (mm_done) state_next = MUL;
            MUL:     if (mm_done) state_next = (bit_idx == '0) ? DONE : SQR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and multiplier operand selection. The multiplier is launched in
    // the first cycle of each arithmetic state, before it has been started.
    always_comb begin
        busy     = (state != IDLE) && (state != DONE);
        done     = (state == DONE);
        mm_start = 1'b0;
        mm_a     = acc;
        mm_b     = acc;
        case (state)
            REDUCE: begin
                mm_start = !mm_pending;
                mm_a     = base_r;
                mm_b     = WIDTH'(1);
            end
            SQR: begin
                mm_start = !mm_pending;
            end
            MUL: begin
                mm_start = !mm_pending;
                mm_b     = b_val;
            end
            default: begin
                mm_start = 1'b0;
            end
        endcase
    end

    // The product is always computed; only the exponent bit decides whether
    // it replaces the accumulator, keeping the schedule data-independent.
    assign mul_acc = exp_r[bit_idx] ? mm_p : acc;

    // Operand latches, accumulator and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r     <= '0;
            exp_r      <= '0;
            mod_r      <= '0;
            acc        <= '0;
            b_val      <= '0;
            bit_idx    <= '0;
            mm_pending <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
        end else begin
            if (mm_start) begin
                mm_pending <= 1'b1;
            end else if (mm_done) begin
                mm_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base_i;
                        exp_r  <= exp_i;
                        mod_r  <= mod_i;
                        err    <= 1'b0;
                    end
                end
                CHECK: begin
                    bit_idx <= BW'(WIDTH - 1);
                    if (mod_r == '0) begin
                        err    <= 1'b1;
                        result <= '0;
                    end else begin
                        acc <= (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                end
                REDUCE: begin
                    if (mm_done) b_val <= mm_p;
                end
                SQR: begin
                    if (mm_done) acc <= mm_p;
                end
                MUL: begin
                    if (mm_done) begin
                        acc <= mul_acc;
                        if (bit_idx == '0) begin
                            result <= mul_acc;
                        end else begin
                            bit_idx <= bit_idx - BW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core
// Scoreboarded bench for the modular exponentiation core. Each accepted
// start pushes the expected result, error flag and latency; a monitor pops
// and compares whenever done pulses.
module tb_rsa_modexp_core;

    localparam int W       = 8;
    localparam int LAT     = 2 + (2 * W + 1) * (W + 1);
    localparam int LAT_ERR = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] base_i;
    logic [W-1:0] exp_i;
    logic [W-1:0] mod_i;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    typedef struct {
        int res;
        int err;
        int lat;
        int t0;
    } expect_t;

    expect_t sb[$];
    expect_t cur;
    int      compared   = 0;
    int      mismatched = 0;
    int      cycle      = 0;

    rsa_modexp_core #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .base_i(base_i),
        .exp_i (exp_i),
        .mod_i (mod_i),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: plain repeated multiplication, with m==0 flagged as an error.
    function automatic int model(input int b, input int e, input int m);
        int r;
        if (m == 0) return 0;
        r = 1 % m;
        for (int k = 0; k < e; k++) r = (r * b) % m;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issue one start once the core is idle and record what should come back.
    task automatic applyStimulus(input int b, input int e, input int m,
                                 input int res, input int er);
        expect_t x;
        for (int k = 0; k < 2000 && (busy || done); k++) @(negedge clk);
        base_i = W'(b);
        exp_i  = W'(e);
        mod_i  = W'(m);
        start  = 1'b1;
        x.res  = res;
        x.err  = er;
        x.lat  = (m == 0) ? LAT_ERR : LAT;
        x.t0   = cycle + 1;
        sb.push_back(x);
        @(negedge clk);
        start  = 1'b0;
        base_i = W'($urandom);
        exp_i  = W'($urandom);
        mod_i  = W'($urandom);
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("err_cleared_on_start", int'(err), 0);
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 2000 && (sb.size() != 0 || busy || done); k++) @(negedge clk);
        checkOutput("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            checkOutput("busy_with_done", int'(busy), 0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                cur = sb.pop_front();
                checkOutput("result", int'(result), cur.res);
                checkOutput("err", int'(err), cur.err);
                checkOutput("latency", cycle + 1 - cur.t0, cur.lat);
            end
        end
    end

    initial begin
        int b, e, m;
        rst    = 1'b1;
        start  = 1'b0;
        base_i = '0;
        exp_i  = '0;
        mod_i  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with known answers.
        applyStimulus(9, 7, 143, 48, 0);     waitIdle();
        applyStimulus(48, 103, 143, 9, 0);   waitIdle();
        applyStimulus(4, 13, 97, 93, 0);     waitIdle();
        applyStimulus(200, 1, 143, 57, 0);   waitIdle();
        applyStimulus(33, 0, 97, 1, 0);      waitIdle();
        applyStimulus(5, 3, 1, 0, 0);        waitIdle();
        applyStimulus(255, 255, 255, 0, 0);  waitIdle();
        applyStimulus(0, 5, 7, 0, 0);        waitIdle();
        applyStimulus(123, 45, 0, 0, 1);     waitIdle();
        checkOutput("err_held", int'(err), 1);
        applyStimulus(3, 4, 10, 1, 0);       waitIdle();

        // Start re-pulsed mid-run must be ignored.
        applyStimulus(4, 13, 97, 93, 0);
        repeat (38) @(negedge clk);
        base_i = 8'd2;
        exp_i  = 8'd3;
        mod_i  = 8'd11;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitIdle();

        // Reset in the middle of a run, then a clean restart.
        applyStimulus(9, 7, 143, 48, 0);
        repeat (68) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_result", int'(result), 0);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(48, 103, 143, 9, 0);   waitIdle();

        // Randomized operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            b = int'($urandom_range(0, 255));
            e = int'($urandom_range(0, 255));
            m = int'($urandom_range(0, 255));
            if (i % 7 == 3) m = 0;
            if (i % 7 == 5) m = 1;
            applyStimulus(b, e, m, model(b, e, m), (m == 0) ? 1 : 0);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
